addshift_mult8: RTL

ADDSHIFT_MULT8 -- requirements
Module: addshift_mult8

---
 rtl/mult_pkg.sv | 23 ++
 rtl/lookahead_adder9.sv | 48 ++++
 rtl/addshift_mult8.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// mult_pkg -- shared types and constants for the add-shift multiplier.
//   state_t    : controller states (IDLE, ADD, SHIFT, HOLD)
//   WIDTH      : operand width (8)
//   ITERATIONS : add/shift iterations per multiply (8)
//   extend9    : widens an operand to WIDTH+1 bits, sign- or zero-extended
package mult_pkg;

    localparam int WIDTH      = 8;
    localparam int ITERATIONS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    function automatic logic [WIDTH:0] extend9(input logic [WIDTH-1:0] v,
                                               input logic sign_mode);
        return {sign_mode & v[WIDTH-1], v};
    endfunction

endpackage

// File: rtl/lookahead_adder9.sv
// lookahead_adder9 -- 9-bit adder built from two 4-bit carry-lookahead
// groups plus a single top bit. The group carries are themselves
// computed by lookahead from the group generate/propagate terms.
// Ports:
//   a, b  in  9  addends
//   cin   in  1  carry-in (set with an inverted b to subtract)
//   sum   out 9  a + b + cin, carry-out of bit 8 dropped
module lookahead_adder9
    import mult_pkg::*;
(
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           cin,
    output logic [WIDTH:0] sum
);

    // Returns {group_generate, group_propagate, sum[3:0]}.
    function automatic logic [5:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       gg;
        logic       pg;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pg   = &p;
        return {gg, pg, p ^ c};
    endfunction

    logic [5:0] grp0;
    logic [5:0] grp1;
    logic       c4;
    logic       c8;

    assign grp0 = cla4(a[3:0], b[3:0], cin);
    assign c4   = grp0[5] | (grp0[4] & cin);
    assign grp1 = cla4(a[7:4], b[7:4], c4);
    assign c8   = grp1[5] | (grp1[4] & grp0[5]) | (grp1[4] & grp0[4] & cin);
    assign sum  = {a[8] ^ b[8] ^ c8, grp1[3:0], grp0[3:0]};

endmodule

// File: rtl/addshift_mult8.sv
// addshift_mult8 -- sequential 8x8 add-shift multiplier, one bit of the
// multiplier (B[0]) consumed per ADD/SHIFT pair, 16 busy cycles total.
// Product ends up in {A,B}; X is the extension bit above A.
// Build option: define MULT_SIGNED_EN for a two's-complement multiply
// (sign-extended adds, subtract on the last iteration, arithmetic shift);
// leave it undefined for an unsigned multiply (X = carry-out, logical shift).
// Ports:
//   Clk           in   1  clock, rising edge
//   Reset         in   1  asynchronous, active-high
//   Run           in   1  rising edge starts a multiply (IDLE only)
//   ClearA_LoadB  in   1  in IDLE: A<=0, X<=0, B<=S (wins over Run)
//   S             in   8  multiplicand and B-load source
//   Aval          out  8  register A (upper product byte)
//   Bval          out  8  register B (multiplier / lower product byte)
//   Xval          out  1  extension bit X
//   Busy          out  1  high in ADD and SHIFT
//   Done          out  1  high in HOLD
//   state_dbg     out  2  current controller state (state_t encoding)
//
// Handshake: Run is a level; a start is a 0->1 transition seen in IDLE.
// The result is held with Done=1 until Run returns low, which releases
// the block back to IDLE.
module addshift_mult8
    import mult_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       state_dbg
);

`ifdef MULT_SIGNED_EN
    localparam logic SIGN_MODE = 1'b1;
`else
    localparam logic SIGN_MODE = 1'b0;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic             x_q, x_n;
    logic [2:0]       cnt_q, cnt_n;
    logic             run_q;
    logic             run_armed;
    logic             run_rise;
    logic             last_iter;
    logic             subtract;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic [WIDTH:0]   add_sum;

    // run_armed stays low after reset until Run has been seen low, so a
    // Run level held through reset cannot masquerade as a fresh edge.
    assign run_rise  = Run & ~run_q & run_armed;
    assign last_iter = (cnt_q == 3'(ITERATIONS - 1));
    // The sign bit of a two's-complement multiplier has negative weight,
    // so its partial product is subtracted.
    assign subtract  = SIGN_MODE & last_iter;
    assign add_a     = extend9(a_q, SIGN_MODE);
    assign add_b     = subtract ? ~extend9(S, SIGN_MODE) : extend9(S, SIGN_MODE);

    lookahead_adder9 u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (subtract),
        .sum (add_sum)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_q       <= '0;
            b_q       <= '0;
            x_q       <= 1'b0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            run_armed <= 1'b0;
        end else begin
            a_q   <= a_n;
            b_q   <= b_n;
            x_q   <= x_n;
            cnt_q <= cnt_n;
            run_q <= Run;
            if (!Run) begin
                run_armed <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a_q;
        b_n     = b_q;
        x_n     = x_q;
        cnt_n   = cnt_q;
        case (state)
            ST_IDLE: begin
                if (ClearA_LoadB) begin
                    a_n = '0;
                    x_n = 1'b0;
                    b_n = S;
                end else if (run_rise) begin
                    state_n = ST_ADD;
                    a_n     = '0;
                    x_n     = 1'b0;
                    cnt_n   = '0;
                end
            end
            ST_ADD: begin
                state_n = ST_SHIFT;
                if (b_q[0]) begin
                    {x_n, a_n} = add_sum;
                end else begin
                    x_n = SIGN_MODE & a_q[WIDTH-1];
                end
            end
            ST_SHIFT: begin
                {x_n, a_n, b_n} = {SIGN_MODE & x_q, x_q, a_q, b_q[WIDTH-1:1]};
                cnt_n           = cnt_q + 3'd1;
                state_n         = last_iter ? ST_HOLD : ST_ADD;
            end
            ST_HOLD: begin
                if (!Run) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign Aval      = a_q;
    assign Bval      = b_q;
    assign Xval      = x_q;
    assign Busy      = (state == ST_ADD) || (state == ST_SHIFT);
    assign Done      = (state == ST_HOLD);
    assign state_dbg = state;

endmodule
